// File: rtl/uart_core_cfg.sv
// uart_core_cfg: runtime-configurable UART transmitter and receiver.
// One shared oversample tick drives both directions. Frame format
// (data length, parity, stop bits) is latched per frame, so a controller
// can reprogram it at any time without corrupting a frame in flight.
module uart_core_cfg #(
    parameter int DLEN_MAX = 9,
    parameter int DIV_W    = 16,
    parameter int OVS      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DIV_W-1:0]              i_div,
    input  logic [$clog2(DLEN_MAX+1)-1:0] i_dlen,
    input  logic [1:0]                    i_par,
    input  logic                          i_stop2,
    output logic                          o_tx,
    input  logic                          i_wvalid,
    output logic                          o_wready,
    input  logic [DLEN_MAX-1:0]           i_wdata,
    input  logic                          i_rxs,
    output logic                          o_rvalid,
    input  logic                          i_rready,
    output logic [DLEN_MAX-1:0]           o_rdata,
    output logic                          o_perr,
    output logic                          o_ferr,
    output logic                          o_brk,
    output logic                          o_rovr
);

    localparam int LW = $clog2(DLEN_MAX + 1);
    localparam int TW = $clog2(OVS);
    localparam logic [DLEN_MAX-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    // Tick generator state
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_cur;
    logic [DIV_W-1:0] div_eff;
    logic             tick;

    // Shared configuration decode
    logic [LW-1:0]       dlen_eff;
    logic [DLEN_MAX-1:0] wdata_masked;

    // TX state
    tx_state_t           tx_state;
    logic [TW-1:0]       tx_tcnt;
    logic [LW-1:0]       tx_bcnt;
    logic [DLEN_MAX-1:0] tx_sh;
    logic [LW-1:0]       tx_dlen;
    logic                tx_par_en;
    logic                tx_pbit;
    logic                tx_stop2;
    logic                tx_second;
    logic                tx_armed;
    logic                tx_last;

    // RX state
    rx_state_t           rx_state;
    logic [TW-1:0]       rx_tcnt;
    logic [LW-1:0]       rx_bcnt;
    logic [DLEN_MAX-1:0] rx_sh;
    logic [LW-1:0]       rx_dlen;
    logic [1:0]          rx_par;
    logic                rx_ones;
    logic                rx_zero;
    logic                rx_perr;
    logic                rx_sample;
    logic                rx_fin;

    assign div_eff      = (i_div == '0) ? DIV_W'(1) : i_div;
    assign tick         = (tick_cnt == div_cur - DIV_W'(1));
    assign dlen_eff     = (i_dlen < LW'(5)) ? LW'(5) :
                          (i_dlen > LW'(DLEN_MAX)) ? LW'(DLEN_MAX) : i_dlen;
    assign wdata_masked = i_wdata & ~(ALL_ONES << dlen_eff);
    assign tx_last      = (tx_tcnt == TW'(OVS - 1));
    assign rx_sample    = tick && ((rx_state == RX_START) ? (rx_tcnt == TW'(OVS/2 - 1))
                                                          : (rx_tcnt == TW'(OVS - 1)));
    assign rx_fin       = (rx_state == RX_STOP) && rx_sample;

    // Free-running tick counter; a new divisor is picked up only at wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt <= '0;
            div_cur  <= DIV_W'(1);
        end else if (tick) begin
            tick_cnt <= '0;
            div_cur  <= div_eff;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Transmit FSM: format latched on accept, each bit held for OVS ticks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state  <= TX_IDLE;
            tx_tcnt   <= '0;
            tx_bcnt   <= '0;
            tx_sh     <= '0;
            tx_dlen   <= LW'(5);
            tx_par_en <= 1'b0;
            tx_pbit   <= 1'b0;
            tx_stop2  <= 1'b0;
            tx_second <= 1'b0;
            tx_armed  <= 1'b0;
            o_tx      <= 1'b1;
            o_wready  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    o_tx     <= 1'b1;
                    o_wready <= 1'b1;
                    if (i_wvalid && o_wready) begin
                        o_wready  <= 1'b0;
                        tx_sh     <= wdata_masked;
                        tx_dlen   <= dlen_eff;
                        tx_par_en <= (i_par == 2'b01) || (i_par == 2'b10);
                        tx_pbit   <= (i_par == 2'b01) ? ~^wdata_masked : ^wdata_masked;
                        tx_stop2  <= i_stop2;
                        tx_armed  <= 1'b0;
                        tx_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (!tx_armed) begin
                            tx_armed <= 1'b1;
                            o_tx     <= 1'b0;
                            tx_tcnt  <= '0;
                        end else if (tx_last) begin
                            tx_tcnt  <= '0;
                            o_tx     <= tx_sh[0];
                            tx_sh    <= tx_sh >> 1;
                            tx_bcnt  <= LW'(1);
                            tx_state <= TX_DATA;
                        end else begin
                            tx_tcnt <= tx_tcnt + TW'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_last) begin
                            tx_tcnt <= '0;
                            if (tx_bcnt == tx_dlen) begin
                                if (tx_par_en) begin
                                    o_tx     <= tx_pbit;
                                    tx_state <= TX_PARITY;
                                end else begin
                                    o_tx      <= 1'b1;
                                    tx_second <= 1'b0;
                                    tx_state  <= TX_STOP;
                                end
                            end else begin
                                o_tx    <= tx_sh[0];
                                tx_sh   <= tx_sh >> 1;
                                tx_bcnt <= tx_bcnt + LW'(1);
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt + TW'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        if (tx_last) begin
                            tx_tcnt   <= '0;
                            o_tx      <= 1'b1;
                            tx_second <= 1'b0;
                            tx_state  <= TX_STOP;
                        end else begin
                            tx_tcnt <= tx_tcnt + TW'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (tx_last) begin
                            tx_tcnt <= '0;
                            if (tx_stop2 && !tx_second) begin
                                tx_second <= 1'b1;
                            end else begin
                                tx_state <= TX_IDLE;
                                o_wready <= 1'b1;
                            end
                        end else begin
                            tx_tcnt <= tx_tcnt + TW'(1);
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Receive FSM: mid-bit sampling, format latched at start-bit detect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_sh    <= '0;
            rx_dlen  <= LW'(5);
            rx_par   <= 2'b00;
            rx_ones  <= 1'b0;
            rx_zero  <= 1'b0;
            rx_perr  <= 1'b0;
        end else begin
            if (tick && (rx_state != RX_IDLE) && (rx_state != RX_WAIT_HIGH)) begin
                rx_tcnt <= rx_sample ? '0 : rx_tcnt + TW'(1);
            end
            case (rx_state)
                RX_IDLE: begin
                    if (!i_rxs) begin
                        rx_state <= RX_START;
                        rx_tcnt  <= '0;
                        rx_dlen  <= dlen_eff;
                        rx_par   <= i_par;
                        rx_sh    <= '0;
                        rx_bcnt  <= '0;
                        rx_ones  <= 1'b0;
                        rx_zero  <= 1'b1;
                        rx_perr  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_sample) begin
                        rx_state <= i_rxs ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_sh[rx_bcnt] <= i_rxs;
                        rx_ones        <= rx_ones ^ i_rxs;
                        rx_zero        <= rx_zero & ~i_rxs;
                        rx_bcnt        <= rx_bcnt + LW'(1);
                        if (rx_bcnt == rx_dlen - LW'(1)) begin
                            rx_state <= ((rx_par == 2'b01) || (rx_par == 2'b10)) ? RX_PARITY : RX_STOP;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_perr  <= (rx_par == 2'b01) ? ~(rx_ones ^ i_rxs) : (rx_ones ^ i_rxs);
                        rx_zero  <= rx_zero & ~i_rxs;
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_sample) begin
                        rx_state <= i_rxs ? RX_IDLE : RX_WAIT_HIGH;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (i_rxs) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Output holding register: a completed frame is dropped if the held word is unread
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rvalid <= 1'b0;
            o_rdata  <= '0;
            o_perr   <= 1'b0;
            o_ferr   <= 1'b0;
            o_brk    <= 1'b0;
            o_rovr   <= 1'b0;
        end else begin
            o_rovr <= 1'b0;
            if (rx_fin) begin
                if (!o_rvalid || i_rready) begin
                    o_rvalid <= 1'b1;
                    o_rdata  <= rx_sh;
                    o_perr   <= rx_perr;
                    o_ferr   <= ~i_rxs;
                    o_brk    <= rx_zero & ~i_rxs;
                end else begin
                    o_rovr <= 1'b1;
                end
            end else if (o_rvalid && i_rready) begin
                o_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// tb_uart_core_cfg: table-driven, hand-sequenced and randomized checks of
// uart_core_cfg against a frame-level reference model.
module tb_uart_core_cfg;

    typedef struct {
        int div;
        int dlen;
        int par;
        int stop2;
        int wdata;
        int exp_rdata;
        int exp_len;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] i_div;
    logic [3:0]  i_dlen;
    logic [1:0]  i_par;
    logic        i_stop2;
    logic        o_tx;
    logic        i_wvalid;
    logic        o_wready;
    logic [8:0]  i_wdata;
    logic        i_rxs;
    logic        o_rvalid;
    logic        i_rready;
    logic [8:0]  o_rdata;
    logic        o_perr;
    logic        o_ferr;
    logic        o_brk;
    logic        o_rovr;

    logic loopback;
    logic rxs_drv;
    assign i_rxs = loopback ? o_tx : rxs_drv;

    int compared   = 0;
    int mismatched = 0;

    logic [8:0] rx_data_log [256];
    logic [2:0] rx_flag_log [256];
    int rx_wr    = 0;
    int rx_rd    = 0;
    int rovr_cnt = 0;

    bit   exp_bits[$];
    vec_t vecs[7];

    uart_core_cfg #(.DLEN_MAX(9), .DIV_W(16), .OVS(16)) dut (
        .clk(clk), .rstn(rstn), .i_div(i_div), .i_dlen(i_dlen), .i_par(i_par),
        .i_stop2(i_stop2), .o_tx(o_tx), .i_wvalid(i_wvalid), .o_wready(o_wready),
        .i_wdata(i_wdata), .i_rxs(i_rxs), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_rdata(o_rdata), .o_perr(o_perr), .o_ferr(o_ferr), .o_brk(o_brk),
        .o_rovr(o_rovr)
    );

    // 100 MHz-style clock
    always #5 clk = ~clk;

    // Log every word handed over and every overrun pulse
    always @(negedge clk) begin
        if (rstn === 1'b1 && o_rvalid === 1'b1 && i_rready === 1'b1) begin
            rx_data_log[rx_wr % 256] = o_rdata;
            rx_flag_log[rx_wr % 256] = {o_perr, o_ferr, o_brk};
            rx_wr++;
        end
        if (o_rovr === 1'b1) rovr_cnt++;
    end

    // Hard stop if something hangs
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int eff_dlen(input int dlen);
        if (dlen < 5) return 5;
        if (dlen > 9) return 9;
        return dlen;
    endfunction

    // Reference frame: start, dlen data bits LSB first, optional parity, stops
    function automatic void build_bits(input int dlen, input int par, input int stop2, input int wdata);
        int d;
        int ones;
        d    = eff_dlen(dlen);
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < d; i++) begin
            bit b;
            b = bit'((wdata >> i) & 1);
            ones += int'(b);
            exp_bits.push_back(b);
        end
        if (par == 1) exp_bits.push_back(bit'(ones % 2 == 0));
        else if (par == 2) exp_bits.push_back(bit'(ones % 2 == 1));
        exp_bits.push_back(1'b1);
        if (stop2 != 0) exp_bits.push_back(1'b1);
    endfunction

    task automatic check_output(input string tag, input int exp_data, input int exp_flags);
        check({tag, "_rxcnt"}, rx_wr - rx_rd, 1);
        if (rx_wr != rx_rd) begin
            check({tag, "_rdata"}, rx_data_log[rx_rd % 256], exp_data);
            check({tag, "_flags"}, rx_flag_log[rx_rd % 256], exp_flags);
        end
        rx_rd = rx_wr;
    endtask

    task automatic drive_bits(input bit bits[$], input int bclk);
        foreach (bits[k]) begin
            rxs_drv = bits[k];
            step(bclk);
        end
        rxs_drv = 1'b1;
    endtask

    // Send one word in loopback; check TX waveform, frame length and RX word
    task automatic apply_stimulus(input int div, input int dlen, input int par, input int stop2,
                                  input int wdata, input int exp_rdata, input int exp_len,
                                  input string tag, input bit scramble);
        int divx;
        int bclk;
        int mism;
        int found;
        bit wave[$];
        bit want;
        divx     = (div == 0) ? 1 : div;
        bclk     = 16 * divx;
        loopback = 1'b1;
        i_div    = 16'(div);
        i_dlen   = 4'(dlen);
        i_par    = 2'(par);
        i_stop2  = 1'(stop2);
        build_bits(dlen, par, stop2, wdata);
        rx_rd = rx_wr;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (o_wready === 1'b1) begin
                found = 1;
                break;
            end
        end
        check({tag, "_ready"}, found, 1);
        if (found == 0) return;
        i_wvalid = 1'b1;
        i_wdata  = 9'(wdata);
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
        found = 0;
        for (int i = 0; i < 100 * divx; i++) begin
            @(negedge clk);
            if (o_tx === 1'b0) begin
                found = 1;
                break;
            end
        end
        check({tag, "_start"}, found, 1);
        if (found == 0) return;
        wave.push_back(o_tx);
        while (wave.size() < exp_len + 64) begin
            @(negedge clk);
            if (o_wready === 1'b1) break;
            wave.push_back(o_tx);
            if (scramble && wave.size() == 4) begin
                i_dlen  = 4'($urandom);
                i_par   = 2'($urandom);
                i_stop2 = 1'($urandom);
            end
        end
        check({tag, "_len"}, wave.size(), exp_len);
        mism = 0;
        foreach (wave[k]) begin
            want = (k / bclk < exp_bits.size()) ? exp_bits[k / bclk] : 1'b1;
            if (wave[k] != want) mism++;
        end
        check({tag, "_wave_errs"}, mism, 0);
        check_output(tag, exp_rdata, 0);
    endtask

    initial begin
        // div, dlen, par, stop2, wdata, expected rdata, expected frame clocks
        vecs[0] = '{4, 8,  0, 0, 'h0A5, 'h0A5, 640};
        vecs[1] = '{4, 7,  2, 1, 'h155, 'h055, 704};
        vecs[2] = '{0, 3,  1, 0, 'h0FF, 'h01F, 128};
        vecs[3] = '{2, 9,  2, 1, 'h1FF, 'h1FF, 416};
        vecs[4] = '{1, 15, 3, 0, 'h1AB, 'h1AB, 176};
        vecs[5] = '{2, 6,  1, 1, 'h000, 'h000, 320};
        vecs[6] = '{3, 5,  0, 1, 'h155, 'h015, 384};

        rstn     = 1'b0;
        i_div    = 16'd4;
        i_dlen   = 4'd8;
        i_par    = 2'b00;
        i_stop2  = 1'b0;
        i_wvalid = 1'b0;
        i_wdata  = '0;
        i_rready = 1'b1;
        loopback = 1'b1;
        rxs_drv  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", o_tx, 1);
        check("rst_wready", o_wready, 0);
        check("rst_rvalid", o_rvalid, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_flags", {o_perr, o_ferr, o_brk, o_rovr}, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wready_after", o_wready, 1);

        // Table vectors in loopback
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].div, vecs[i].dlen, vecs[i].par, vecs[i].stop2, vecs[i].wdata,
                           vecs[i].exp_rdata, vecs[i].exp_len, $sformatf("vec%0d", i), 1'b0);
        end

        // Randomized frames, format scrambled mid-frame to prove per-frame latching
        for (int n = 0; n < 12; n++) begin
            int div;
            int dlen;
            int par;
            int stop2;
            int wdata;
            int d;
            div   = int'($urandom_range(0, 2));
            dlen  = int'($urandom_range(0, 15));
            par   = int'($urandom_range(0, 3));
            stop2 = int'($urandom_range(0, 1));
            wdata = int'($urandom_range(0, 511));
            d     = eff_dlen(dlen);
            build_bits(dlen, par, stop2, wdata);
            apply_stimulus(div, dlen, par, stop2, wdata, wdata & ((1 << d) - 1),
                           exp_bits.size() * 16 * ((div == 0) ? 1 : div),
                           $sformatf("rnd%0d", n), 1'b1);
        end

        // Receiver driven directly, bit period 32 clocks
        rxs_drv  = 1'b1;
        loopback = 1'b0;
        i_div    = 16'd2;
        i_dlen   = 4'd8;
        i_par    = 2'b01;
        i_stop2  = 1'b0;
        step(64);
        rx_rd = rx_wr;

        // 8O1 with inverted parity bit
        build_bits(8, 1, 0, 'h3C);
        exp_bits[9] = ~exp_bits[9];
        drive_bits(exp_bits, 32);
        step(64);
        check_output("par_err", 'h3C, 3'b100);

        // Break: 12 bit periods low, then a normal frame
        i_par   = 2'b00;
        rxs_drv = 1'b0;
        step(12 * 32);
        rxs_drv = 1'b1;
        step(64);
        check_output("break", 0, 3'b011);
        build_bits(8, 0, 0, 'h5A);
        drive_bits(exp_bits, 32);
        step(64);
        check_output("after_break", 'h5A, 0);

        // Overrun: two frames with the consumer stalled
        begin
            int base;
            base     = rovr_cnt;
            i_rready = 1'b0;
            build_bits(8, 0, 0, 'h11);
            drive_bits(exp_bits, 32);
            step(32);
            build_bits(8, 0, 0, 'h22);
            drive_bits(exp_bits, 32);
            step(64);
            @(negedge clk);
            check("ovr_rvalid", o_rvalid, 1);
            check("ovr_rdata_held", o_rdata, 'h11);
            check("ovr_pulses", rovr_cnt - base, 1);
            check("ovr_nothing_taken", rx_wr - rx_rd, 0);
            @(posedge clk);
            #1;
            i_rready = 1'b1;
            step(4);
            check_output("ovr_first", 'h11, 0);
            @(negedge clk);
            check("ovr_rvalid_clear", o_rvalid, 0);
            check("ovr_rdata_kept", o_rdata, 'h11);
            step(1);
        end

        // Glitch of 3 ticks must not start a frame
        rxs_drv = 1'b0;
        step(6);
        rxs_drv = 1'b1;
        step(3 * 32);
        check("glitch_rxcnt", rx_wr - rx_rd, 0);
        check("glitch_rvalid", o_rvalid, 0);
        build_bits(8, 0, 0, 'h33);
        drive_bits(exp_bits, 32);
        step(64);
        check_output("after_glitch", 'h33, 0);

        // Reset in the middle of a transmitted frame
        loopback = 1'b1;
        i_div    = 16'd1;
        rx_rd    = rx_wr;
        @(negedge clk);
        i_wvalid = 1'b1;
        i_wdata  = 9'h0F0;
        @(posedge clk);
        #1;
        i_wvalid = 1'b0;
        step(40);
        check("midrst_tx_low_before", o_tx, 0);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_tx_now", o_tx, 1);
        check("midrst_wready_now", o_wready, 0);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check("midrst_wready_release", o_wready, 0);
        @(posedge clk);
        #1;
        check("midrst_wready_after", o_wready, 1);
        step(300);
        check("midrst_no_rx", rx_wr - rx_rd, 0);
        check("midrst_tx_idle", o_tx, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
Runtime-configurable UART transmit/receive core, the next generation of the fixed 8N1 uart_tx/uart_rx pair.
- Adds a programmable baud divisor, 5..DLEN_MAX data bits, none/odd/even parity, and 1 or 2 stop bits.
- Receiver uses OVS-times oversampling and reports parity, framing, break and overrun errors.
- Sits between the TX/RX FIFOs and the pins; the AXI-lite controller drives the configuration inputs.

Parameters:
DLEN_MAX, 9, widest supported data length; i_wdata/o_rdata width
DIV_W, 16, width of the baud divisor
OVS, 16, oversample ticks per bit (even, >=4)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
i_div  in  DIV_W  clocks per oversample tick; 0 is treated as 1
i_dlen  in  $clog2(DLEN_MAX+1)  data bits; values <5 are treated as 5, values >DLEN_MAX as DLEN_MAX
i_par  in  2  00 none, 01 odd, 10 even, 11 none
i_stop2  in  1  1 = two stop bits on TX
o_tx  out  1  serial out, idle high
i_wvalid  in  1  TX word valid
o_wready  out  1  TX ready to accept
i_wdata  in  DLEN_MAX  TX word, LSB transmitted first
i_rxs  in  1  serial in, already synchronised to clk
o_rvalid  out  1  RX word valid (held until accepted)
i_rready  in  1  RX consumer ready
o_rdata  out  DLEN_MAX  RX word, right-aligned, zero-extended
o_perr  out  1  parity error for the o_rdata word
o_ferr  out  1  framing error for the o_rdata word
o_brk  out  1  break detected for the o_rdata word
o_rovr  out  1  one-clock pulse: frame dropped on overrun

Behaviour:
Reset (asynchronous, takes effect immediately):
- o_tx=1, o_wready=0 during reset, 1 on the first clock after release.
- o_rvalid=0, o_rdata=0, all flags 0.
- Both FSMs go to IDLE; the tick counter clears.
- A frame in flight is abandoned with no output.

Tick generator:
- Free-running counter 0..max(i_div,1)-1; tick asserts for one clock when count reaches its maximum.
- One bit period = OVS ticks.
- A change to i_div takes effect at the next counter wrap.

Configuration:
- i_dlen, i_par and i_stop2 are latched per frame: TX on accept, RX on start-bit detect.
- Mid-frame changes do not affect the frame in flight.

TX FSM (IDLE, START, DATA, PARITY, STOP):
- IDLE: o_wready=1; accept when i_wvalid&o_wready; o_wready drops the next clock. Bits of i_wdata at and above i_dlen are ignored.
- Bit timing: the start bit begins on the first tick after accept; each state lasts OVS ticks.
- DATA: sends i_dlen bits, LSB first.
- PARITY: present only when enabled. Odd parity makes total ones odd; even makes total ones even.
- STOP: 1 or 2 bit periods at high.
- Return: back to IDLE, and o_wready=1 on the clock after the last stop tick.

RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH):
- IDLE: i_rxs=0 enters START.
- START: samples at OVS/2 ticks. If the sample is 1 it is a glitch: return to IDLE with no output.
- DATA/PARITY/STOP: each sampled OVS ticks after the previous sample (mid-bit).
- Stop bits: only the first stop bit is checked, regardless of i_stop2.
- Completion at the stop sample:
  - o_perr = parity mismatch.
  - o_ferr = stop sampled 0.
  - o_brk = all data bits, parity bit (if enabled) and stop bit sampled 0.
- On o_ferr, the FSM enters WAIT_HIGH and returns to IDLE only once i_rxs=1. No new frames are detected while low.

RX output handshake:
- Completed frame with o_rvalid=0, or o_rvalid&i_rready in the same clock: load o_rdata and flags, o_rvalid=1 the next clock.
- Completed frame with o_rvalid&~i_rready: o_rovr=1 for one clock; the new frame is dropped and the held word and flags are unchanged.
- o_rvalid&i_rready with no completing frame: o_rvalid=0 the next clock; o_rdata retains its value.

Test Plan:
- 8N1, i_div=4, OVS=16, i_wdata=0xA5, o_tx looped to i_rxs -> bits 0,1,0,1,0,0,1,0,1,1 at 64 clocks each; o_wready returns after 640 clocks; o_rdata=0x0A5 with all flags 0.
- 7E2, i_wdata=0x155 -> only 7 bits sent (0x55); parity bit 0, two stop bits, frame 704 clocks; RX o_rdata=0x055, o_perr=0.
- 8O1 stimulus with the parity bit inverted -> o_rvalid with o_rdata correct and o_perr=1, o_ferr=0.
- i_rxs held low for 12 bit periods, then high -> exactly one o_rvalid with o_rdata=0, o_brk=1, o_ferr=1; the next frame after the line goes high is received normally.
- Two frames received with i_rready=0 -> first word held; o_rovr pulses once at the second stop sample; o_rdata still equals the first word.
- Low pulse on i_rxs of 3 ticks -> no o_rvalid. rstn asserted mid-TX-frame -> o_tx=1 immediately, o_wready=1 one clock after release.
